// File: rtl/clk_rate_gen_pkg.sv
// Shared constants for the rate-strobe generator.
//   Switch and mode codes, plus the default dividers for the board build.
package clk_rate_pkg;

   localparam logic [1:0] MODE_SLOW   = 2'b00;
   localparam logic [1:0] MODE_MEDIUM = 2'b10;
   localparam logic [1:0] MODE_FAST   = 2'b11;
   localparam logic [1:0] CODE_HOLD   = 2'b01;

   localparam int unsigned DEF_DIV_FAST   = 4;
   localparam int unsigned DEF_DIV_MEDIUM = 16;
   localparam int unsigned DEF_DIV_SLOW   = 64;
   localparam int unsigned DEF_DEB_CYCLES = 8;
   localparam int unsigned DEF_CNT_W      = 32;

   // Enumerator values equal the mode codes, so the state drives `mode` directly.
   typedef enum logic [1:0] {
      StSlow   = 2'b00,
      StMedium = 2'b10,
      StFast   = 2'b11
   } mode_e;

endpackage

// File: rtl/clk_rate_gen_if.sv
// Rate switch inputs and strobe outputs of clk_rate_gen.
//   master: drives sw2/sw1, observes the strobes, clkSelect, mode and hold.
//   slave : the generator itself.
interface clk_rate_gen_if;

   logic       sw2;
   logic       sw1;
   logic       tickFast;
   logic       tickMedium;
   logic       tickSlow;
   logic       tickSelect;
   logic       clkSelect;
   logic [1:0] mode;
   logic       hold;

   modport master (
      output sw2, sw1,
      input  tickFast, tickMedium, tickSlow, tickSelect, clkSelect, mode, hold
   );

   modport slave (
      input  sw2, sw1,
      output tickFast, tickMedium, tickSlow, tickSelect, clkSelect, mode, hold
   );

endinterface

// File: rtl/clk_rate_gen_tick_divider.sv
// Free-running divider producing a registered one-cycle strobe every DIV cycles.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   tick  : high in cycles k*DIV-1 (k >= 1), counted from reset release
module tick_divider #(
   parameter int unsigned DIV   = 4,
   parameter int unsigned CNT_W = 32
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   if (DIV < 2) begin : g_bad_div
      $error("tick_divider: DIV must be at least 2");
   end

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q;

   always_comb begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CNT_W'(1);
   end

   // Counter reads DIV-1 in cycle k*DIV-2, so the flop lands the tick in k*DIV-1.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= (cnt_q == CntLast);
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/clk_rate_gen.sv
// Rate strobe generator: three dividers, switch synchroniser/debouncer and a
// mode FSM that commits rate changes only on a slow tick.
//   clk   : board clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : sw2/sw1 in; tickFast/Medium/Slow, tickSelect, clkSelect, mode, hold out
module clk_rate_gen
   import clk_rate_pkg::*;
#(
   parameter int unsigned DIV_FAST   = DEF_DIV_FAST,
   parameter int unsigned DIV_MEDIUM = DEF_DIV_MEDIUM,
   parameter int unsigned DIV_SLOW   = DEF_DIV_SLOW,
   parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES,
   parameter int unsigned CNT_W      = DEF_CNT_W
) (
   input logic           clk,
   input logic           rst_n,
   clk_rate_gen_if.slave bus
);

   // Commits rely on every slow tick coinciding with the other two ticks.
   if ((DIV_SLOW % DIV_MEDIUM) != 0 || (DIV_SLOW % DIV_FAST) != 0) begin : g_bad_ratio
      $error("clk_rate_gen: DIV_SLOW must be a multiple of DIV_MEDIUM and DIV_FAST");
   end
   if (DEB_CYCLES < 1) begin : g_bad_deb
      $error("clk_rate_gen: DEB_CYCLES must be at least 1");
   end

   localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEB_CYCLES - 1);

   logic tick_fast, tick_medium, tick_slow, tick_sel;

   tick_divider #(.DIV(DIV_FAST), .CNT_W(CNT_W)) u_div_fast (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick_fast)
   );

   tick_divider #(.DIV(DIV_MEDIUM), .CNT_W(CNT_W)) u_div_medium (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick_medium)
   );

   tick_divider #(.DIV(DIV_SLOW), .CNT_W(CNT_W)) u_div_slow (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick_slow)
   );

   logic [1:0]       sync1_q, sync2_q, last_q;
   logic [CNT_W-1:0] deb_cnt_q, deb_cnt_d;
   logic             accept_q, accept_d;
   logic [1:0]       code_q, code_d;
   mode_e            state_q, state_d;
   mode_e            pend_q, pend_d;
   logic             pend_vld_q, pend_vld_d;
   logic             hold_q, hold_d;
   logic             csel_q;

   // Debounce: count stable cycles, accept once per stable run. The counter parks
   // one past DebLast so a held switch is not re-accepted every cycle.
   always_comb begin
      deb_cnt_d = deb_cnt_q;
      accept_d  = 1'b0;
      code_d    = code_q;
      if (sync2_q != last_q) begin
         deb_cnt_d = '0;
      end else if (deb_cnt_q == DebLast) begin
         deb_cnt_d = deb_cnt_q + CNT_W'(1);
         accept_d  = 1'b1;
         code_d    = sync2_q;
      end else if (deb_cnt_q < DebLast) begin
         deb_cnt_d = deb_cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d    = state_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      hold_d     = hold_q;
      // The request pending before this cycle commits first; an accept in the same
      // cycle then queues against the post-commit mode.
      if (tick_slow && pend_vld_q) begin
         state_d    = pend_q;
         pend_vld_d = 1'b0;
      end
      if (accept_q) begin
         if (code_q == CODE_HOLD) begin
            hold_d     = 1'b1;
            pend_vld_d = 1'b0;
         end else begin
            hold_d = 1'b0;
            if (mode_e'(code_q) != state_d) begin
               pend_d     = mode_e'(code_q);
               pend_vld_d = 1'b1;
            end else begin
               pend_vld_d = 1'b0;
            end
         end
      end
   end

   // Old mode selects in the commit cycle; all ticks coincide there.
   always_comb begin
      case (state_q)
         StSlow:   tick_sel = tick_slow;
         StMedium: tick_sel = tick_medium;
         StFast:   tick_sel = tick_fast;
         default:  tick_sel = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q    <= 2'b00;
         sync2_q    <= 2'b00;
         last_q     <= 2'b00;
         deb_cnt_q  <= '0;
         accept_q   <= 1'b0;
         code_q     <= 2'b00;
         state_q    <= StSlow;
         pend_q     <= StSlow;
         pend_vld_q <= 1'b0;
         hold_q     <= 1'b0;
         csel_q     <= 1'b0;
      end else begin
         sync1_q    <= {bus.sw2, bus.sw1};
         sync2_q    <= sync1_q;
         last_q     <= sync2_q;
         deb_cnt_q  <= deb_cnt_d;
         accept_q   <= accept_d;
         code_q     <= code_d;
         state_q    <= state_d;
         pend_q     <= pend_d;
         pend_vld_q <= pend_vld_d;
         hold_q     <= hold_d;
         csel_q     <= csel_q ^ tick_sel;
      end
   end

   assign bus.tickFast   = tick_fast;
   assign bus.tickMedium = tick_medium;
   assign bus.tickSlow   = tick_slow;
   assign bus.tickSelect = tick_sel;
   assign bus.clkSelect  = csel_q;
   assign bus.mode       = state_q;
   assign bus.hold       = hold_q;

endmodule

// File: doc/clk_rate_gen.md
Name: clk_rate_gen

Overview:
- Generates the three rate strobes (fast, medium, slow) that the clock-select logic chooses between, from the single board clock. Everything stays in one clock domain; no derived clocks are gated.
- Also synchronises and debounces the two rate switches, and commits rate changes only on a slow-tick boundary.
- Drives a selected tick strobe plus a 50%-duty square wave `clkSelect` for LEDs and counters downstream.

Parameters:
- DIV_FAST, 4: fast tick period, in clk cycles.
- DIV_MEDIUM, 16: medium tick period, in clk cycles.
- DIV_SLOW, 64: slow tick period, in clk cycles.
- DEB_CYCLES, 8: consecutive stable synchronised cycles required to accept a switch code.
- CNT_W, 32: width of the divider and debounce counters.

Ports:
- clk  in  1  board clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- sw2  in  1  rate switch, MSB; asynchronous to clk.
- sw1  in  1  rate switch, LSB; asynchronous to clk.
- tickFast  out  1  one-cycle strobe, period DIV_FAST.
- tickMedium  out  1  one-cycle strobe, period DIV_MEDIUM.
- tickSlow  out  1  one-cycle strobe, period DIV_SLOW.
- tickSelect  out  1  the strobe of the committed mode.
- clkSelect  out  1  toggles on every tickSelect.
- mode  out  2  committed mode code.
- hold  out  1  accepted switch code is invalid (01).

Behaviour:
- Interface decision: one clock `clk`; reset `rst_n` is synchronous and active-low.
- Reset values: all tick outputs 0, `clkSelect` 0, `mode` 2'b00 (slow), `hold` 0.
  - Divider and debounce counters reset to 0; pending-valid cleared.
  - Debounced switch value resets to 00; synchroniser flops reset to 0.
- Cycle numbering: cycle 0 is the first cycle after the edge at which `rst_n` is sampled high.
- Dividers:
  - Each counts 0..DIV-1 and wraps to 0.
  - Its tick is a flop, high exactly in cycles k·DIV−1 (k≥1), one cycle wide.
  - Counters never stop; mode does not affect them.
- Parameter rules (elaboration-time check; fail elaboration if violated):
  - every DIV ≥ 2;
  - DIV_SLOW divisible by DIV_MEDIUM and by DIV_FAST.
  - Consequence: every tickSlow coincides with a tickMedium and a tickFast.
- Switch path:
  - Two-flop synchroniser on {sw2, sw1}, then a debounce counter.
  - The counter resets whenever the synchronised code differs from the previous cycle.
  - When it reaches DEB_CYCLES−1, the code is accepted in the next cycle.
- Accepted code decode:
  - 00 is slow, 10 is medium, 11 is fast.
  - 01 is hold: `hold` goes to 1, and any existing pending request is cancelled.
  - Any valid code sets `hold` to 0.
- Mode FSM:
  - States SLOW, MEDIUM, FAST, plus a one-entry pending register and pending-valid.
  - Accepting a valid code that differs from `mode` loads pending and sets pending-valid; a newer accept overwrites it.
  - Accepting a code equal to `mode` clears pending-valid.
  - In a tickSlow cycle with pending-valid=1: `mode` takes the pending value at the end of that cycle, and pending-valid is cleared.
- Same-cycle accept and tickSlow: the value pending before that cycle commits. The new value becomes pending and commits at the following tickSlow.
- tickSelect:
  - Combinational mux of the three ticks by the current registered `mode`.
  - In the commit cycle, the old mode is used; all ticks coincide there, so there is no glitch or missing edge.
- clkSelect: a flop that inverts at the end of each cycle in which tickSelect=1.
- Reset mid-operation: on the next edge, all state returns to reset values regardless of mode or pending. Cycle numbering restarts.
- The block never produces a tickSelect pulse wider than one cycle.

Decomposition:
- Shared package `clk_rate_pkg`:
  - mode constants MODE_SLOW=2'b00, MODE_MEDIUM=2'b10, MODE_FAST=2'b11, CODE_HOLD=2'b01;
  - default DIV_*/DEB_CYCLES constants for the board build.
- Sub-module `tick_divider` (parameters DIV, CNT_W; ports clk, rst_n, tick), instantiated three times.
- Synchroniser, debounce and mode FSM stay in the top module.

Test Plan:
- Reset release with sw=00 -> tickFast high at cycles 3,7,11; tickMedium at 15,31; tickSlow at 63,127. tickSelect equals tickSlow; clkSelect rises at cycle 64 and falls at 128. mode=00, hold=0.
- sw=11 applied from cycle 10 and held -> accepted at about cycle 20, pending. mode becomes 11 from cycle 64. tickSelect is high at 63 (slow/fast coincide), then 67, 71, 75. clkSelect toggles every 4 cycles from then on.
- sw=11 for 5 cycles, then back to 00 -> never accepted; mode stays 00, pending-valid stays 0, tickSelect unchanged.
- From fast mode, sw=01 held for 20 cycles -> hold=1 after debounce; mode stays 11 across the next tickSlow. Then sw=10 -> hold=0, and mode=10 after the next tickSlow.
- Accept of 10 landing exactly in a tickSlow cycle (pending=11 queued before) -> mode=11 at that boundary, mode=10 at the following tickSlow, 64 cycles later.
- rst_n low for one cycle at cycle 100 in fast mode -> next cycle: all ticks 0, clkSelect 0, mode 00, hold 0. After release, tickFast reappears at relative cycle 3.
